// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit driving an SRAM-like data bus (req / addr_ok / data_ok).
// Aligns store data and strobes, extends load data, flags misaligned accesses and
// stalls the pipeline while a bus transaction is open.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        mem_type,
  input  logic [2:0]        mem_size,
  input  logic              unsigned_flag,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic              result_valid,
  output logic              addr_err_load,
  output logic              addr_err_store
);

  // Decoder field encodings
  localparam logic [1:0] MEM_NOOP      = 2'd0;
  localparam logic [1:0] MEM_LOAD      = 2'd1;
  localparam logic [1:0] MEM_STOR      = 2'd2;
  localparam logic [2:0] SZ_BYTE       = 3'd0;
  localparam logic [2:0] SZ_HALF       = 3'd1;
  localparam logic [2:0] SZ_FULL       = 3'd2;
  localparam logic       ZERO_EXTENDED = 1'b1;

  // FSM states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic              uns_q;
  logic [DATA_W-1:0] load_q;

  logic              is_load, is_store, is_mem;
  logic              misaligned;
  logic              accept;
  logic              capture;
  logic [DATA_W-1:0] st_wdata;
  logic [3:0]        st_wstrb;
  logic [1:0]        bus_size;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_ext;

  assign is_load  = (mem_type == MEM_LOAD);
  assign is_store = (mem_type == MEM_STOR);
  assign is_mem   = is_load | is_store;

  // Alignment check; unknown size codes are treated as misaligned
  always_comb begin
    misaligned = 1'b1;
    case (mem_size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr[0];
      SZ_FULL: misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  assign addr_err_load  = in_valid & is_load & misaligned;
  assign addr_err_store = in_valid & is_store & misaligned;
  assign accept         = in_valid & (mem_type != MEM_NOOP) & is_mem & (state_q == ST_IDLE) &
                          ~flush & ~misaligned;

  // Store lane replication and byte strobes; loads carry no strobes
  always_comb begin
    st_wdata = wdata;
    st_wstrb = 4'b1111;
    bus_size = 2'd2;
    case (mem_size)
      SZ_BYTE: begin
        st_wdata = {4{wdata[7:0]}};
        st_wstrb = 4'b0001 << addr[1:0];
        bus_size = 2'd0;
      end
      SZ_HALF: begin
        st_wdata = {2{wdata[15:0]}};
        st_wstrb = addr[1] ? 4'b1100 : 4'b0011;
        bus_size = 2'd1;
      end
      default: ;
    endcase
    if (!is_store) begin
      st_wdata = '0;
      st_wstrb = 4'b0000;
    end
  end

  // Load lane extraction and extension from the registered request fields
  always_comb begin
    ld_byte = data_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = data_rdata[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'd0:    ld_ext = (uns_q == ZERO_EXTENDED) ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'd1:    ld_ext = (uns_q == ZERO_EXTENDED) ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = data_rdata;
    endcase
  end

  // Transaction FSM; capture marks the cycle the read data is taken
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ: begin
        if (data_addr_ok && data_data_ok) begin
          state_d = ST_DONE;
          capture = 1'b1;
        end else if (data_addr_ok) begin
          // Request already accepted: cannot withdraw, so a flush must drain it
          state_d = flush ? ST_DRAIN : ST_WAIT;
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (data_data_ok) begin
          state_d = ST_DONE;
          capture = 1'b1;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (data_data_ok) state_d = ST_IDLE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and request-field registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= 4'b0000;
      uns_q   <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q    <= is_store;
        size_q  <= bus_size;
        addr_q  <= addr;
        wdata_q <= st_wdata;
        wstrb_q <= st_wstrb;
        uns_q   <= unsigned_flag;
      end
      if (capture && !wr_q) load_q <= ld_ext;
    end
  end

  assign data_req     = (state_q == ST_REQ);
  assign data_wr      = wr_q;
  assign data_size    = size_q;
  assign data_addr    = addr_q;
  assign data_wdata   = wdata_q;
  assign data_wstrb   = wstrb_q;
  assign load_data    = load_q;
  assign result_valid = (state_q == ST_DONE);
  assign stall        = accept | (state_q == ST_REQ) | (state_q == ST_WAIT) |
                        (state_q == ST_DRAIN);

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// accesses checked against a behavioural byte-lane model.
module tb_mem_access_unit;

  localparam logic [1:0] MEM_NOOP = 2'd0;
  localparam logic [1:0] MEM_LOAD = 2'd1;
  localparam logic [1:0] MEM_STOR = 2'd2;
  localparam logic [2:0] SZ_BYTE  = 3'd0;
  localparam logic [2:0] SZ_HALF  = 3'd1;
  localparam logic [2:0] SZ_FULL  = 3'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [1:0]  mem_type;
  logic [2:0]  mem_size;
  logic        unsigned_flag;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        result_valid;
  logic        addr_err_load;
  logic        addr_err_store;

  int checks = 0;
  int fails  = 0;
  logic [31:0] last_load = 32'd0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .mem_type       (mem_type),
    .mem_size       (mem_size),
    .unsigned_flag  (unsigned_flag),
    .addr           (addr),
    .wdata          (wdata),
    .data_req       (data_req),
    .data_wr        (data_wr),
    .data_size      (data_size),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_wstrb     (data_wstrb),
    .data_addr_ok   (data_addr_ok),
    .data_data_ok   (data_data_ok),
    .data_rdata     (data_rdata),
    .stall          (stall),
    .load_data      (load_data),
    .result_valid   (result_valid),
    .addr_err_load  (addr_err_load),
    .addr_err_store (addr_err_store)
  );

  // Reference model: byte-lane arithmetic on the architectural rules
  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [2:0] sz, input logic u);
    longint v;
    int     sh;
    if (sz == SZ_BYTE) begin
      sh = 8 * int'(a % 4);
      v  = longint'((rd >> sh) & 32'hFF);
      if (!u && v >= 128) v = v - 256;
    end else if (sz == SZ_HALF) begin
      sh = 16 * int'((a / 2) % 2);
      v  = longint'((rd >> sh) & 32'hFFFF);
      if (!u && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(rd);
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [2:0] sz);
    if (sz == SZ_BYTE) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == SZ_HALF) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [3:0] ref_wstrb(input logic [31:0] a, input logic [2:0] sz);
    if (sz == SZ_BYTE) return 4'b0001 << (a % 4);
    if (sz == SZ_HALF) return ((a / 2) % 2 == 1) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic ref_misaligned(input logic [31:0] a, input logic [2:0] sz);
    if (sz == SZ_BYTE) return 1'b0;
    if (sz == SZ_HALF) return (a % 2) != 0;
    if (sz == SZ_FULL) return (a % 4) != 0;
    return 1'b1;
  endfunction

  // One access from IDLE; alat = REQ cycles before addr_ok, dlat = WAIT cycles (0 = same cycle)
  task automatic do_access(input logic [1:0] ty, input logic [2:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input int alat, input int dlat);
    logic        st;
    logic [31:0] exp_ld;
    st = (ty == MEM_STOR);
    exp_ld = ref_load(rd, a, sz, u);
    in_valid = 1'b1; mem_type = ty; mem_size = sz; unsigned_flag = u; addr = a; wdata = wd;
    #1;
    if (ref_misaligned(a, sz)) begin
      checks++;
      if (addr_err_load !== !st || addr_err_store !== st || stall !== 1'b0) begin
        fails++;
        $display("FAIL misalign_flags a=%h sz=%0d: got adel=%b ades=%b stall=%b want %b %b 0",
                 a, sz, addr_err_load, addr_err_store, stall, !st, st);
      end
      @(posedge clk); #1;
      checks++;
      if (data_req !== 1'b0) begin
        fails++;
        $display("FAIL misalign_noreq: got req=%b want 0", data_req);
      end
      in_valid = 1'b0; mem_type = MEM_NOOP;
      return;
    end
    checks++;
    if (stall !== 1'b1 || addr_err_load !== 1'b0 || addr_err_store !== 1'b0) begin
      fails++;
      $display("FAIL accept_stall: got stall=%b adel=%b ades=%b want 1 0 0",
               stall, addr_err_load, addr_err_store);
    end
    @(posedge clk); #1;
    checks++;
    if (data_req !== 1'b1 || data_wr !== st || data_addr !== a || data_size !== sz[1:0] ||
        data_wstrb !== (st ? ref_wstrb(a, sz) : 4'b0000)) begin
      fails++;
      $display("FAIL req_fields: got req=%b wr=%b addr=%h size=%0d strb=%b want 1 %b %h %0d %b",
               data_req, data_wr, data_addr, data_size, data_wstrb, st, a, sz,
               st ? ref_wstrb(a, sz) : 4'b0000);
    end
    if (st) begin
      checks++;
      if (data_wdata !== ref_wdata(wd, sz)) begin
        fails++;
        $display("FAIL store_wdata: got %h want %h", data_wdata, ref_wdata(wd, sz));
      end
    end
    for (int i = 0; i < alat; i++) begin
      @(posedge clk); #1;
      checks++;
      if (data_req !== 1'b1 || stall !== 1'b1 || data_addr !== a) begin
        fails++;
        $display("FAIL req_hold: got req=%b stall=%b addr=%h want 1 1 %h",
                 data_req, stall, data_addr, a);
      end
    end
    data_addr_ok = 1'b1;
    data_data_ok = (dlat == 0);
    data_rdata   = (dlat == 0) ? rd : $urandom;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    if (dlat > 0) begin
      checks++;
      if (data_req !== 1'b0 || stall !== 1'b1 || result_valid !== 1'b0) begin
        fails++;
        $display("FAIL wait_state: got req=%b stall=%b rv=%b want 0 1 0",
                 data_req, stall, result_valid);
      end
      for (int i = 1; i < dlat; i++) begin
        data_rdata = $urandom;
        @(posedge clk); #1;
      end
      data_data_ok = 1'b1; data_rdata = rd;
      @(posedge clk); #1;
      data_data_ok = 1'b0;
    end
    if (!st) last_load = exp_ld;
    checks++;
    if (result_valid !== 1'b1 || stall !== 1'b0 || load_data !== last_load) begin
      fails++;
      $display("FAIL done: got rv=%b stall=%b load=%h want 1 0 %h",
               result_valid, stall, load_data, last_load);
    end
    in_valid = 1'b0; mem_type = MEM_NOOP;
    @(posedge clk); #1;
    checks++;
    if (result_valid !== 1'b0 || load_data !== last_load) begin
      fails++;
      $display("FAIL pulse_end: got rv=%b load=%h want 0 %h", result_valid, load_data, last_load);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; mem_type = MEM_NOOP; mem_size = SZ_BYTE;
    unsigned_flag = 1'b0; addr = '0; wdata = '0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({data_req, data_wr, result_valid, stall, data_size, data_wstrb} !== 10'd0 ||
        data_addr !== 32'd0 || data_wdata !== 32'd0 || load_data !== 32'd0) begin
      fails++;
      $display("FAIL reset_state: got req=%b wr=%b rv=%b stall=%b size=%0d strb=%b addr=%h wd=%h ld=%h want all 0",
               data_req, data_wr, result_valid, stall, data_size, data_wstrb, data_addr,
               data_wdata, load_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_ext();
    do_access(MEM_LOAD, SZ_BYTE, 1'b0, 32'h1003, 32'h0, 32'h80FF_FF7F, 1, 1);
    checks++;
    if (load_data !== 32'hFFFF_FF80) begin
      fails++; $display("FAIL lb_signed: got %h want ffffff80", load_data);
    end
    do_access(MEM_LOAD, SZ_HALF, 1'b1, 32'h1002, 32'h0, 32'hBEEF_1234, 0, 2);
    checks++;
    if (load_data !== 32'h0000_BEEF) begin
      fails++; $display("FAIL lhu: got %h want 0000beef", load_data);
    end
    do_access(MEM_LOAD, SZ_HALF, 1'b0, 32'h1002, 32'h0, 32'hBEEF_1234, 2, 1);
    checks++;
    if (load_data !== 32'hFFFF_BEEF) begin
      fails++; $display("FAIL lh_signed: got %h want ffffbeef", load_data);
    end
  endtask

  task automatic test_store_lanes();
    do_access(MEM_STOR, SZ_BYTE, 1'b0, 32'h2001, 32'h1234_56AB, 32'h0, 0, 1);
    checks++;
    if (data_wdata !== 32'hABAB_ABAB || data_wstrb !== 4'b0010 || data_wr !== 1'b1) begin
      fails++;
      $display("FAIL sb_lanes: got wd=%h strb=%b wr=%b want ababab ab 0010 1",
               data_wdata, data_wstrb, data_wr);
    end
  endtask

  task automatic test_misaligned();
    do_access(MEM_LOAD, SZ_FULL, 1'b0, 32'h3002, 32'h0, 32'h0, 0, 0);
    do_access(MEM_STOR, SZ_HALF, 1'b0, 32'h3001, 32'h0, 32'h0, 0, 0);
    do_access(MEM_LOAD, 3'd5, 1'b0, 32'h3000, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic test_flush();
    // Flush while the address phase is still pending cancels the request
    in_valid = 1'b1; mem_type = MEM_LOAD; mem_size = SZ_FULL; addr = 32'h4000;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (data_req !== 1'b1) begin
        fails++; $display("FAIL flush_req_hold: got req=%b want 1", data_req);
      end
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; mem_type = MEM_NOOP;
    #1;
    checks++;
    if (data_req !== 1'b0 || stall !== 1'b0 || result_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_cancel: got req=%b stall=%b rv=%b want 0 0 0",
               data_req, stall, result_valid);
    end
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (result_valid !== 1'b0) begin
        fails++; $display("FAIL flush_cancel_rv: got %b want 0", result_valid);
      end
    end
    // Flush after address accept drains the data phase and discards the result
    in_valid = 1'b1; mem_type = MEM_LOAD; mem_size = SZ_FULL; addr = 32'h5004;
    @(posedge clk); #1;
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; mem_type = MEM_NOOP;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stall !== 1'b1 || data_req !== 1'b0 || result_valid !== 1'b0) begin
        fails++;
        $display("FAIL drain_hold: got stall=%b req=%b rv=%b want 1 0 0",
                 stall, data_req, result_valid);
      end
      @(posedge clk); #1;
    end
    data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || stall !== 1'b0 || load_data !== last_load) begin
      fails++;
      $display("FAIL drain_discard: got rv=%b stall=%b load=%h want 0 0 %h",
               result_valid, stall, load_data, last_load);
    end
    // Stray data_ok in IDLE is ignored
    data_data_ok = 1'b1; data_rdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || load_data !== last_load) begin
      fails++;
      $display("FAIL stray_data_ok: got rv=%b load=%h want 0 %h",
               result_valid, load_data, last_load);
    end
  endtask

  task automatic test_reset_in_wait();
    in_valid = 1'b1; mem_type = MEM_STOR; mem_size = SZ_BYTE; addr = 32'h6003;
    wdata = 32'h0000_0055;
    @(posedge clk); #1;
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    #2;
    rst_n = 1'b0; in_valid = 1'b0; mem_type = MEM_NOOP;
    #1;
    checks++;
    if ({data_req, data_wr, result_valid, stall, data_size, data_wstrb} !== 10'd0 ||
        data_addr !== 32'd0 || data_wdata !== 32'd0 || load_data !== 32'd0) begin
      fails++;
      $display("FAIL reset_in_wait: got req=%b wr=%b rv=%b stall=%b strb=%b addr=%h wd=%h ld=%h want all 0",
               data_req, data_wr, result_valid, stall, data_wstrb, data_addr, data_wdata,
               load_data);
    end
    last_load = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_latency();
    do_access(MEM_LOAD, SZ_HALF, 1'b0, 32'h7002, 32'h0, 32'h8001_7FFF, 0, 0);
    do_access(MEM_STOR, SZ_FULL, 1'b0, 32'h7004, 32'hCAFE_F00D, 32'h0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  ty;
      logic [2:0]  sz;
      logic [31:0] a;
      ty = ($urandom_range(0, 1) == 0) ? MEM_LOAD : MEM_STOR;
      sz = ($urandom_range(0, 9) == 0) ? 3'(3 + $urandom_range(0, 4)) : 3'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == SZ_HALF) a[0] = 1'b0;
        if (sz == SZ_FULL) a[1:0] = 2'b00;
      end
      do_access(ty, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_store_lanes();
    test_misaligned();
    test_flush();
    test_reset_in_wait();
    test_zero_latency();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
